// File: rtl/rata_wr_monitor_if.sv
// CPU data-memory write channel between the bus master and the RATA write monitor.
// The master drives the burst address phase and data-beat qualifiers; the monitor returns wr_ready.
interface rata_wr_monitor_if;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [3:0]  wr_len;
  logic        wr_ready;
  logic        wr_beat_valid;
  logic [3:0]  wr_strb;
  logic        wr_abort;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_len,
    input  wr_ready,
    output wr_beat_valid,
    output wr_strb,
    output wr_abort
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_len,
    output wr_ready,
    input  wr_beat_valid,
    input  wr_strb,
    input  wr_abort
  );
endinterface

// File: rtl/rata_wr_monitor.sv
// Write monitor ahead of the RATA attestation FSM: expands bursts into beat addresses and flags AR/LMT writes.
// Define RATA_WR_MON_DMA_EN to add a single-beat DMA write port checked alongside the CPU channel.
module rata_wr_monitor #(
  parameter logic [31:0] AR_MIN     = 32'h0000_1000,
  parameter logic [31:0] AR_MAX     = 32'h0000_1FFF,
  parameter logic [31:0] LMT_MIN    = 32'h0000_2000,
  parameter logic [31:0] LMT_MAX    = 32'h0000_200F,
  parameter int          BEAT_BYTES = 4,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  rata_wr_monitor_if.slave  bus,
  input  logic [31:0]       PC,
`ifdef RATA_WR_MON_DMA_EN
  input  logic              dma_wen,
  input  logic [31:0]       dma_addr,
  input  logic [3:0]        dma_strb,
`endif
  output logic              Mod_Mem_AR,
  output logic              Mod_Mem_LMT,
  output logic              lmt_violation,
  output logic [CNT_W-1:0]  ar_mod_count,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Inclusive range test written as an offset compare so a zero lower bound
  // does not turn into a constant comparison.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr - lo) <= (hi - lo);
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [4:0]        beats_left_q, beats_left_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              mod_ar_q, mod_ar_d;
  logic              mod_lmt_q, mod_lmt_d;
  logic              lmt_viol_q, lmt_viol_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              beat_accept;
  logic              cpu_check;
  logic              cpu_ar;
  logic              cpu_lmt;
  logic              dma_ar;
  logic              dma_lmt;
  logic [1:0]        cnt_inc;
  logic [CNT_W:0]    cnt_sum;

  assign beat_accept = (state_q == BURST) && bus.wr_beat_valid && !bus.wr_abort;
  assign cpu_check   = beat_accept && (bus.wr_strb != 4'b0000);
  assign cpu_ar      = cpu_check && in_range(cur_addr_q, AR_MIN, AR_MAX);
  assign cpu_lmt     = cpu_check && in_range(cur_addr_q, LMT_MIN, LMT_MAX);

`ifdef RATA_WR_MON_DMA_EN
  logic dma_check;
  assign dma_check = dma_wen && (dma_strb != 4'b0000);
  assign dma_ar    = dma_check && in_range(dma_addr, AR_MIN, AR_MAX);
  assign dma_lmt   = dma_check && in_range(dma_addr, LMT_MIN, LMT_MAX);
`else
  assign dma_ar    = 1'b0;
  assign dma_lmt   = 1'b0;
`endif

  // Burst tracking: next state, current beat address and remaining beat count.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          cur_addr_d   = bus.wr_addr;
          beats_left_d = {1'b0, bus.wr_len} + 5'd1;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (bus.wr_abort) begin
          state_d = IDLE;
        end else if (bus.wr_beat_valid) begin
          cur_addr_d   = cur_addr_q + 32'(BEAT_BYTES);
          beats_left_d = beats_left_q - 5'd1;
          if (beats_left_q == 5'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ready_d = (state_d == IDLE);
    busy_d     = (state_d == BURST);
  end

  // Flags, sticky LMT status and the saturating AR counter.
  always_comb begin
    mod_ar_d   = cpu_ar || dma_ar;
    mod_lmt_d  = cpu_lmt || dma_lmt;
    cnt_inc    = {1'b0, cpu_ar} + {1'b0, dma_ar};
    cnt_sum    = {1'b0, cnt_q} + (CNT_W+1)'(cnt_inc);
    cnt_d      = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    lmt_viol_d = lmt_viol_q;
    if (mod_lmt_d) begin
      lmt_viol_d = 1'b1;
    end else if (PC == 32'h0000_0000) begin
      lmt_viol_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= 32'h0000_0000;
      beats_left_q <= 5'd0;
      wr_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      mod_ar_q     <= 1'b0;
      mod_lmt_q    <= 1'b0;
      lmt_viol_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      wr_ready_q   <= wr_ready_d;
      busy_q       <= busy_d;
      mod_ar_q     <= mod_ar_d;
      mod_lmt_q    <= mod_lmt_d;
      lmt_viol_q   <= lmt_viol_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign busy          = busy_q;
  assign Mod_Mem_AR    = mod_ar_q;
  assign Mod_Mem_LMT   = mod_lmt_q;
  assign lmt_violation = lmt_viol_q;
  assign ar_mod_count  = cnt_q;

  // Handshake outputs are mutually exclusive; a LMT pulse always leaves the sticky bit set.
  a_ready_busy_excl: assert property (@(posedge clk) disable iff (!reset_n)
    wr_ready_q != busy_q);
  a_lmt_sets_sticky: assert property (@(posedge clk) disable iff (!reset_n)
    mod_lmt_q |-> lmt_viol_q);

endmodule

// File: tb/tb_rata_wr_monitor.sv
// Scoreboard bench for rata_wr_monitor: stimulus queues expected flag pulses, a negedge monitor pops and compares.
module tb_rata_wr_monitor;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [31:0]       pc;
  logic              mod_ar;
  logic              mod_lmt;
  logic              lmt_violation;
  logic [CNT_W-1:0]  ar_mod_count;
  logic              busy;
`ifdef RATA_WR_MON_DMA_EN
  logic              dma_wen;
  logic [31:0]       dma_addr;
  logic [3:0]        dma_strb;
`endif

  rata_wr_monitor_if bus ();

  rata_wr_monitor #(
    .AR_MIN (32'h0000_0000),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .PC            (pc),
`ifdef RATA_WR_MON_DMA_EN
    .dma_wen       (dma_wen),
    .dma_addr      (dma_addr),
    .dma_strb      (dma_strb),
`endif
    .Mod_Mem_AR    (mod_ar),
    .Mod_Mem_LMT   (mod_lmt),
    .lmt_violation (lmt_violation),
    .ar_mod_count  (ar_mod_count),
    .busy          (busy)
  );

  typedef struct {
    int               at;
    bit               ar;
    bit               lmt;
    logic [CNT_W-1:0] cnt;
    bit               viol;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               cyc = 0;
  int               n_pass = 0;
  int               n_total = 0;
  logic [CNT_W-1:0] m_cnt;
  bit               m_viol;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h required %0h", name, act, req);
    else n_pass++;
  endtask

  // Monitor: every flag pulse must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (mod_ar || mod_lmt) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got ar=%0b lmt=%0b at cycle %0d, required no pulse",
                 mod_ar, mod_lmt, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc == mon_e.at && mod_ar == mon_e.ar && mod_lmt == mon_e.lmt &&
            ar_mod_count == mon_e.cnt && lmt_violation == mon_e.viol) begin
          n_pass++;
          $display("cycle %0d pulse ar=%0b lmt=%0b cnt=%0d viol=%0b ok",
                   cyc, mod_ar, mod_lmt, ar_mod_count, lmt_violation);
        end else begin
          $display("FAIL pulse: got cyc=%0d ar=%0b lmt=%0b cnt=%0d viol=%0b, required cyc=%0d ar=%0b lmt=%0b cnt=%0d viol=%0b",
                   cyc, mod_ar, mod_lmt, ar_mod_count, lmt_violation,
                   mon_e.at, mon_e.ar, mon_e.lmt, mon_e.cnt, mon_e.viol);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_ar_hit();
    m_cnt = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + 1'b1;
  endtask

  task automatic start_burst(input logic [31:0] addr, input logic [3:0] len);
    check("ready_before_req", {31'd0, bus.wr_ready}, 32'd1);
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_len  = len;
    tick();
    bus.wr_req  = 1'b0;
    check("busy_in_burst", {31'd0, busy}, 32'd1);
  endtask

  task automatic beat(input logic [3:0] strb, input bit exp_ar, input bit exp_lmt);
    bus.wr_beat_valid = 1'b1;
    bus.wr_strb       = strb;
    if (exp_ar || exp_lmt) begin
      if (exp_ar) model_ar_hit();
      if (exp_lmt) m_viol = 1'b1;
      sb_q.push_back('{cyc + 1, exp_ar, exp_lmt, m_cnt, m_viol});
    end
    tick();
    bus.wr_beat_valid = 1'b0;
    bus.wr_strb       = 4'h0;
  endtask

  initial begin
    reset_n           = 1'b0;
    pc                = 32'h0000_0100;
    bus.wr_req        = 1'b0;
    bus.wr_addr       = 32'h0;
    bus.wr_len        = 4'h0;
    bus.wr_beat_valid = 1'b0;
    bus.wr_strb       = 4'h0;
    bus.wr_abort      = 1'b0;
`ifdef RATA_WR_MON_DMA_EN
    dma_wen  = 1'b0;
    dma_addr = 32'h0;
    dma_strb = 4'h0;
`endif
    m_cnt  = '0;
    m_viol = 1'b0;

    tick();
    tick();
    check("rst_ar",    {31'd0, mod_ar}, 32'd0);
    check("rst_lmt",   {31'd0, mod_lmt}, 32'd0);
    check("rst_viol",  {31'd0, lmt_violation}, 32'd0);
    check("rst_cnt",   {28'd0, ar_mod_count}, 32'd0);
    check("rst_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single AR write
    start_burst(32'h0000_1004, 4'd0);
    beat(4'hF, 1'b1, 1'b0);
    check("single_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("single_cnt", {28'd0, ar_mod_count}, 32'd1);
    tick();

    // Reset held for two cycles in the middle of a burst with a beat present
    start_burst(32'h0000_1000, 4'd3);
    beat(4'hF, 1'b1, 1'b0);
    bus.wr_beat_valid = 1'b1;
    bus.wr_strb       = 4'hF;
    reset_n           = 1'b0;
    tick();
    tick();
    m_cnt  = '0;
    m_viol = 1'b0;
    check("midrst_ar",    {31'd0, mod_ar}, 32'd0);
    check("midrst_cnt",   {28'd0, ar_mod_count}, 32'd0);
    check("midrst_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    reset_n           = 1'b1;
    bus.wr_beat_valid = 1'b0;
    bus.wr_strb       = 4'h0;
    tick();

    // Burst straddling the AR/LMT boundary, then PC = 0 clears the sticky bit
    start_burst(32'h0000_1FF8, 4'd3);
    beat(4'hF, 1'b1, 1'b0);
    beat(4'hF, 1'b1, 1'b0);
    beat(4'hF, 1'b0, 1'b1);
    beat(4'hF, 1'b0, 1'b1);
    check("straddle_viol", {31'd0, lmt_violation}, 32'd1);
    check("straddle_cnt", {28'd0, ar_mod_count}, 32'd2);
    pc = 32'h0;
    tick();
    m_viol = 1'b0;
    check("pc0_clear", {31'd0, lmt_violation}, 32'd0);
    pc = 32'h0000_0100;

    // Strobe-less beat still advances; set beats clear-with-PC=0; LMT_MAX upper edge
    start_burst(32'h0000_2008, 4'd2);
    beat(4'h0, 1'b0, 1'b0);
    pc = 32'h0;
    beat(4'hF, 1'b0, 1'b1);
    beat(4'hF, 1'b0, 1'b0);
    m_viol = 1'b0;
    check("lmt_edge_viol_cleared", {31'd0, lmt_violation}, 32'd0);
    pc = 32'h0000_0100;

    // Gapped beats followed by an abort that coincides with a valid beat
    start_burst(32'h0000_1000, 4'd7);
    beat(4'hF, 1'b1, 1'b0);
    tick();
    beat(4'hF, 1'b1, 1'b0);
    bus.wr_abort      = 1'b1;
    bus.wr_beat_valid = 1'b1;
    bus.wr_strb       = 4'hF;
    tick();
    bus.wr_abort = 1'b0;
    check("abort_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    tick();
    bus.wr_beat_valid = 1'b0;
    bus.wr_strb       = 4'h0;
    check("abort_cnt", {28'd0, ar_mod_count}, 32'd4);

    // Address wrap from the top of memory into AR (AR_MIN = 0)
    start_burst(32'hFFFF_FFF8, 4'd3);
    beat(4'hF, 1'b0, 1'b0);
    beat(4'hF, 1'b0, 1'b0);
    beat(4'hF, 1'b1, 1'b0);
    beat(4'h2, 1'b1, 1'b0);
    check("wrap_busy", {31'd0, busy}, 32'd0);
    check("wrap_cnt", {28'd0, ar_mod_count}, 32'd6);

`ifdef RATA_WR_MON_DMA_EN
    // CPU and DMA both hit AR in one cycle, then a DMA-only LMT hit in IDLE
    start_burst(32'h0000_1000, 4'd0);
    dma_wen  = 1'b1;
    dma_addr = 32'h0000_0100;
    dma_strb = 4'hF;
    bus.wr_beat_valid = 1'b1;
    bus.wr_strb       = 4'hF;
    model_ar_hit();
    model_ar_hit();
    sb_q.push_back('{cyc + 1, 1'b1, 1'b0, m_cnt, m_viol});
    tick();
    bus.wr_beat_valid = 1'b0;
    check("dma_cnt_plus2", {28'd0, ar_mod_count}, 32'd8);
    dma_addr = 32'h0000_2000;
    m_viol   = 1'b1;
    sb_q.push_back('{cyc + 1, 1'b0, 1'b1, m_cnt, m_viol});
    tick();
    dma_wen = 1'b0;
    pc      = 32'h0;
    tick();
    m_viol  = 1'b0;
    pc      = 32'h0000_0100;
`endif

    // Sixteen-beat burst plus one more AR write: counter saturates
    start_burst(32'h0000_1000, 4'd15);
    for (int i = 0; i < 16; i++) beat(4'hF, 1'b1, 1'b0);
    check("len16_done_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("len16_done_busy",  {31'd0, busy}, 32'd0);
    start_burst(32'h0000_1FFC, 4'd0);
    beat(4'hF, 1'b1, 1'b0);
    check("sat_cnt", {28'd0, ar_mod_count}, 32'd15);

    tick();
    tick();
    tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rata_wr_monitor.md
Name: rata_wr_monitor

Overview:
- Bus-side write monitor directly upstream of the RATA attestation FSM.
- Watches the CPU data-memory write channel, which carries single and burst writes, and expands each burst into per-beat addresses.
- Checks every written beat against the AR (attestation region) and LMT (last-modification-time) regions, then drives the registered Mod_Mem_AR / Mod_Mem_LMT pulses consumed downstream.
- Also keeps a sticky LMT-violation status and a saturating AR-modification counter for debug.

Parameters:
- AR_MIN, 32'h0000_1000, AR region lower bound (inclusive)
- AR_MAX, 32'h0000_1FFF, AR region upper bound (inclusive)
- LMT_MIN, 32'h0000_2000, LMT region lower bound (inclusive)
- LMT_MAX, 32'h0000_200F, LMT region upper bound (inclusive)
- BEAT_BYTES, 4, address increment per beat
- CNT_W, 16, width of the AR modification counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_req  in  1  write-burst request (address phase)
- wr_addr  in  32  start byte address of burst
- wr_len  in  4  burst length minus one (0 = single beat, 15 = 16 beats)
- wr_ready  out  1  address phase accepted when wr_req & wr_ready
- wr_beat_valid  in  1  data beat present this cycle
- wr_strb  in  4  byte strobes of the beat; 4'b0000 = no write
- wr_abort  in  1  abandon current burst
- PC  in  32  program counter; used to clear sticky status
- Mod_Mem_AR  out  1  registered pulse: beat wrote into AR
- Mod_Mem_LMT  out  1  registered pulse: beat wrote into LMT
- lmt_violation  out  1  sticky LMT-write status
- ar_mod_count  out  CNT_W  saturating count of AR-writing beats
- busy  out  1  high while in BURST

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = IDLE; wr_ready = 1.
  - Mod_Mem_AR, Mod_Mem_LMT, lmt_violation, busy = 0; ar_mod_count = 0.
  - Reset mid-burst discards the burst; no flag is raised for the beat present in the reset cycle.
- FSM states are IDLE and BURST.
  - IDLE: wr_ready = 1, busy = 0. On wr_req, latch cur_addr = wr_addr and beats_left = wr_len + 1 (5-bit), then go to BURST. wr_beat_valid in IDLE is ignored.
  - BURST: wr_ready = 0, busy = 1. wr_req is ignored.
  - A beat is accepted when wr_beat_valid & !wr_abort. On accept: cur_addr += BEAT_BYTES with modulo-2^32 wrap (32'hFFFF_FFFC + 4 = 0), and beats_left decrements. When the last beat is accepted (beats_left == 1), go to IDLE; wr_ready is 1 on the following cycle.
  - wr_abort in BURST: go to IDLE next cycle; the beat in that cycle is not checked. Abort outranks wr_beat_valid.
- Region check on each accepted beat with wr_strb != 0: in_ar = AR_MIN <= cur_addr <= AR_MAX; in_lmt = LMT_MIN <= cur_addr <= LMT_MAX. The check uses the beat's aligned address only; strobes only gate it.
- Output latency: exactly 1 cycle. Mod_Mem_AR = registered in_ar; Mod_Mem_LMT = registered in_lmt. Each is high for one cycle per qualifying beat, so consecutive qualifying beats give continuous highs.
- Overlapping regions: a beat in both regions raises both flags in the same cycle.
- ar_mod_count increments by 1 on the same edge Mod_Mem_AR is set, and saturates at all-ones.
- lmt_violation is set on the same edge Mod_Mem_LMT is set. It clears on an edge where PC == 0 and no LMT beat is being flagged; set has priority over clear.
- A beat with wr_strb == 0 is accepted and advances the address, but raises no flag.

Optional Feature:
- Macro: RATA_WR_MON_DMA_EN.
- Defined: adds inputs dma_wen (1), dma_addr (32) and dma_strb (4), a single-beat DMA write port checked every cycle in any state with the same region logic.
  - Mod_Mem_AR and Mod_Mem_LMT are the OR of the CPU-beat and DMA results, with the same 1-cycle latency.
  - ar_mod_count adds +2 (saturating) when both sources hit AR in the same cycle.
- Undefined: DMA ports are absent and the flags come from the CPU channel only.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles mid-burst -> all outputs 0, wr_ready = 1, count = 0; the next burst starts cleanly.
- Single write: wr_addr = 0x1004, wr_len = 0, strb = F -> Mod_Mem_AR high exactly 1 cycle after the beat, Mod_Mem_LMT = 0, count = 1, return to IDLE.
- Burst straddle: wr_addr = 0x1FF8, wr_len = 3, 4 valid beats (0x1FF8, 0x1FFC, 0x2000, 0x2004) -> AR pulses on beats 1-2, LMT pulses on beats 3-4, lmt_violation set; then PC = 0 -> lmt_violation cleared next edge.
- Abort and gaps: wr_len = 7, beats at 0x1000 and 0x1004 with an idle cycle between them, then wr_abort -> 2 AR pulses, FSM in IDLE the cycle after abort, wr_ready = 1.
- Wrap and strobe: wr_addr = 0xFFFF_FFF8, wr_len = 3, AR_MIN = 0 -> addresses wrap to 0x0/0x4; a beat with strb = 0 gives no pulse but the address still advances.
- Saturation (CNT_W = 4): 17 AR beats -> ar_mod_count holds at 15; with RATA_WR_MON_DMA_EN, simultaneous CPU and DMA AR hits in one cycle -> count += 2.
